// File: rtl/alu_74382_serial_seq.sv
// Bit-serial-by-chunk sequencer: runs a wide 74382-style operation through one
// SLICE_W-bit ALU slice, one chunk per clock, LSB chunk first, carry chained via a register.

module alu_74382 #(
    parameter int OPERAND_W = 4,
    parameter int RESULT_W  = 4
) (
    input  logic [2:0]           sel,
    input  logic                 carry_in,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic [RESULT_W-1:0]  result,
    output logic                 carry_out,
    output logic                 overflow
);
    logic [OPERAND_W-1:0] w_x;
    logic [OPERAND_W-1:0] w_y;
    logic [OPERAND_W:0]   w_sum;

    always_comb begin
        w_x = a;
        w_y = b;
        // Subtraction is addition of the one's complement; carry_in=1 means no borrow.
        case (sel)
            3'b001: begin
                w_x = b;
                w_y = ~a;
            end
            3'b010: w_y = ~b;
            default: ;
        endcase
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {{OPERAND_W{1'b0}}, carry_in};

        result    = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (sel)
            3'b001, 3'b010, 3'b011: begin
                result    = RESULT_W'(w_sum[OPERAND_W-1:0]);
                carry_out = w_sum[OPERAND_W];
                overflow  = (w_x[OPERAND_W-1] == w_y[OPERAND_W-1]) &&
                            (w_sum[OPERAND_W-1] != w_x[OPERAND_W-1]);
            end
            3'b100:  result = RESULT_W'(a ^ b);
            3'b101:  result = RESULT_W'(a | b);
            3'b110:  result = RESULT_W'(a & b);
            3'b111:  result = '1;
            default: result = '0;
        endcase
    end
endmodule

module alu_74382_serial_seq #(
    parameter int SLICE_W    = 4,
    parameter int NUM_SLICES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_sel,
    input  logic                          in_carry,
    input  logic [SLICE_W*NUM_SLICES-1:0] in_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] out_result,
    output logic                          out_carry,
    output logic                          out_overflow,
    output logic                          busy
);
    localparam int W     = SLICE_W * NUM_SLICES;
    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [2:0]           r_sel;
    logic [W-1:0]         r_a;
    logic [W-1:0]         r_b;
    logic                 r_carry;
    logic [IDX_W-1:0]     r_idx;
    logic [SLICE_W-1:0]   r_acc [NUM_SLICES];
    logic [W-1:0]         r_result;
    logic                 r_cout;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_arith;
    logic [SLICE_W-1:0]   w_a_chunks [NUM_SLICES];
    logic [SLICE_W-1:0]   w_b_chunks [NUM_SLICES];
    logic [W-1:0]         w_acc_flat;
    logic [W-1:0]         w_full;
    logic [SLICE_W-1:0]   w_alu_result;
    logic                 w_alu_cout;
    logic                 w_alu_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLICES; gi++) begin : g_chunk
            assign w_a_chunks[gi] = r_a[gi*SLICE_W +: SLICE_W];
            assign w_b_chunks[gi] = r_b[gi*SLICE_W +: SLICE_W];
            assign w_acc_flat[gi*SLICE_W +: SLICE_W] = r_acc[gi];
        end
    endgenerate

    alu_74382 #(
        .OPERAND_W (SLICE_W),
        .RESULT_W  (SLICE_W)
    ) u_alu (
        .sel       (r_sel),
        .carry_in  (r_carry),
        .a         (w_a_chunks[r_idx]),
        .b         (w_b_chunks[r_idx]),
        .result    (w_alu_result),
        .carry_out (w_alu_cout),
        .overflow  (w_alu_ovf)
    );

    assign in_ready     = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_last       = (r_idx == LAST_IDX);
    assign w_arith      = (r_sel == 3'b001) || (r_sel == 3'b010) || (r_sel == 3'b011);
    assign out_valid    = (r_state == S_DONE);
    assign busy         = (r_state == S_RUN) || (r_state == S_DONE);
    assign out_result   = r_result;
    assign out_carry    = r_cout;
    assign out_overflow = r_ovf;

    // The final chunk goes straight from the ALU into the output word, so the
    // output register only ever sees complete results.
    always_comb begin
        w_full                   = w_acc_flat;
        w_full[W-1 -: SLICE_W]   = w_alu_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_state_next = in_valid ? S_RUN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < NUM_SLICES; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_accept) begin
            r_sel   <= in_sel;
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_carry;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc[r_idx] <= w_alu_result;
            r_carry      <= w_alu_cout;
            if (w_last) begin
                r_result <= w_full;
                r_cout   <= w_arith && w_alu_cout;
                r_ovf    <= w_arith && w_alu_ovf;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_74382_serial_seq.sv
// Self-checking bench for alu_74382_serial_seq: directed test-plan steps plus
// randomized operations checked against a full-width arithmetic reference model.

module tb_alu_74382_serial_seq;
    localparam int SLICE_W    = 4;
    localparam int NUM_SLICES = 4;
    localparam int W          = SLICE_W * NUM_SLICES;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_sel;
    logic         in_carry;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_carry;
    logic         out_overflow;
    logic         busy;

    int tests = 0;
    int fails = 0;

    alu_74382_serial_seq #(
        .SLICE_W    (SLICE_W),
        .NUM_SLICES (NUM_SLICES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_carry     (in_carry),
        .in_a         (in_a),
        .in_b         (in_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic; returns {carry, overflow, result}.
    function automatic logic [W+1:0] model(input logic [2:0] sel, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic cin);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W:0]   s;
        logic         c;
        logic         v;
        logic [W-1:0] r;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        x = a;
        y = b;
        if (sel == 3'd1) begin x = b; y = ~a; end
        if (sel == 3'd2) begin x = a; y = ~b; end
        s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        case (sel)
            3'd1, 3'd2, 3'd3: begin
                r = s[W-1:0];
                c = s[W];
                v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
            end
            3'd4: r = a ^ b;
            3'd5: r = a | b;
            3'd6: r = a & b;
            3'd7: r = '1;
            default: r = '0;
        endcase
        return {c, v, r};
    endfunction

    task automatic run_op(input string tag, input logic [2:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin, input logic [W-1:0] exp_r,
                          input logic exp_c, input logic exp_v);
        int n;
        in_sel   = sel;
        in_a     = a;
        in_b     = b;
        in_carry = cin;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(NUM_SLICES));
        check({tag, "_result"}, 32'(out_result), 32'(exp_r));
        check({tag, "_carry"}, 32'(out_carry), 32'(exp_c));
        check({tag, "_ovf"}, 32'(out_overflow), 32'(exp_v));
        $display("[TB] %s sel=%0d a=%04h b=%04h cin=%0d -> res=%04h c=%0d v=%0d lat=%0d",
                 tag, sel, a, b, cin, out_result, out_carry, out_overflow, n);
        if (out_ready) begin
            @(posedge clk); #1;
            check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [W+1:0] m;
        logic [2:0]   rs;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           bad;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_carry  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(out_result), 32'd0);
        check("rst_carry", 32'(out_carry), 32'd0);
        check("rst_ovf", 32'(out_overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        run_op("add_carry_chain", 3'd3, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("add_wrap",        3'd3, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",         3'd3, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("a_minus_b",       3'd2, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        run_op("b_minus_a",       3'd1, 16'h0003, 16'h0010, 1'b1, 16'h000D, 1'b1, 1'b0);
        run_op("xor",             3'd4, 16'hA5A5, 16'h0FF0, 1'b1, 16'hAA55, 1'b0, 1'b0);
        run_op("clear",           3'd0, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_op("preset",          3'd7, 16'h1234, 16'h5678, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        run_op("bp_first", 3'd3, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", 32'(out_result), 32'h3333);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        in_sel    = 3'd3;
        in_a      = 16'h1234;
        in_b      = 16'h1111;
        in_carry  = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("bp_same_cycle_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_back_to_run", 32'(out_valid), 32'd0);
        check("bp_run_busy", 32'(busy), 32'd1);
        bad = 0;
        while (!out_valid && bad < 20) begin
            @(posedge clk); #1;
            bad++;
        end
        check("bp_second_latency", 32'(bad), 32'(NUM_SLICES));
        check("bp_second_result", 32'(out_result), 32'h2345);
        $display("[TB] bp_second res=%04h lat=%0d", out_result, bad);
        @(posedge clk); #1;

        // Reset in the middle of RUN discards the operation.
        in_sel   = 3'd3;
        in_a     = 16'hFFFF;
        in_b     = 16'h0001;
        in_carry = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrun_rst_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_result", 32'(out_result), 32'd0);
        check("midrun_rst_carry", 32'(out_carry), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrun_rel_ready", 32'(in_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        check("midrun_no_stale", 32'(bad), 32'd0);
        $display("[TB] midrun reset: stale valid cycles=%0d", bad);

        for (int i = 0; i < 24; i++) begin
            rs = 3'($urandom_range(0, 7));
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            m  = model(rs, ra, rb, rc);
            run_op("rand", rs, ra, rb, rc, m[W-1:0], m[W+1], m[W]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_74382_serial_seq.md
Name: alu_74382_serial_seq

Overview:
- Sequencer that runs wide arithmetic/logic operations through one shared alu_74382 slice, one slice-width chunk per clock, LSB chunk first.
- Carry is chained between chunks through an internal register, so a single 4-bit 74382 datapath does the work of an N-slice alu_chain at 1/N throughput.
- Sits between a requester (valid/ready operand interface) and a consumer (valid/ready result interface).
- Instantiates exactly one alu_74382 with OPERAND_W = RESULT_W = SLICE_W.

Parameters:
- SLICE_W, 4: width of the single alu_74382 instance.
- NUM_SLICES, 4: chunks per operation; total operand width W = SLICE_W*NUM_SLICES (16 by default); legal range 1..16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  sequencer can accept a request this cycle.
- in_sel  in  3  74382 function code: 000 clear, 001 B-A, 010 A-B, 011 A+B, 100 xor, 101 or, 110 and, 111 preset.
- in_carry  in  1  carry into chunk 0; 1 = no borrow for subtract.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_result  out  W  full-width result.
- out_carry  out  1  carry out of the top chunk.
- out_overflow  out  1  signed overflow of the top chunk.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset: async assert forces IDLE. While rst is high and after release: out_valid=0, out_result=0, out_carry=0, out_overflow=0, busy=0, internal carry/index cleared. in_ready=1 from the first cycle after rst deasserts.
- States: IDLE, RUN, DONE.
- Accept handshake: in_valid & in_ready on a clock edge. in_ready = (state==IDLE) | (state==DONE & out_ready); it is combinational from out_ready.
- On accept:
  - Register in_sel, in_a, in_b.
  - Carry register takes in_carry.
  - Chunk index takes 0.
  - Next state is RUN.
  - Inputs are don't-care afterwards.
- RUN, each cycle at chunk index k:
  - The ALU is fed sel, chunk k of A, chunk k of B, and the carry register.
  - On the edge, the ALU result is written into result chunk k and the carry register takes the ALU carry_out.
  - If k == NUM_SLICES-1: latch ALU carry_out into out_carry and ALU overflow into out_overflow, then go to DONE. Otherwise k increments.
- Latency: out_valid rises exactly NUM_SLICES edges after the accept edge (4 by default).
- DONE:
  - out_valid=1.
  - out_result, out_carry and out_overflow are held stable until out_valid & out_ready.
  - On that handshake without a new accept: go to IDLE, out_valid=0, and outputs keep their last value.
  - On that handshake with a same-cycle accept: go straight to RUN with the new operands. Throughput is then one result per NUM_SLICES+... cycles with no idle gap.
- Flags:
  - For sel 000, 100, 101, 110 and 111, out_carry and out_overflow are forced to 0, regardless of what the ALU drives.
  - Clear gives result 0.
  - Preset gives all ones.
  - Logic ops ignore in_carry.
- Requests while busy are not accepted (in_ready=0); the requester must hold them.
- Partial results are never visible: out_result updates only by the final-chunk write, through a separate output register loaded at the RUN to DONE transition.
- Reset mid-RUN or mid-DONE: the operation is discarded, out_valid drops immediately (async), and no result is reported.
- NUM_SLICES=1: RUN lasts one cycle. Behaviour equals a registered alu_74382.

Test Plan:
- A+B (011), a=0x00FF, b=0x0001, cin=0 -> out_result=0x0100, carry 0, ovf 0; out_valid exactly 4 edges after the accept edge.
- A+B, a=0xFFFF, b=0x0001, cin=0 -> 0x0000, carry 1, ovf 0. Then a=0x7FFF, b=0x0001 -> 0x8000, carry 0, ovf 1.
- A-B (010), a=0x0000, b=0x0001, cin=1 -> 0xFFFF, carry 0 (borrow). B-A (001), a=0x0003, b=0x0010, cin=1 -> 0x000D, carry 1.
- Logic ops:
  - xor, a=0xA5A5, b=0x0FF0, cin=1 -> 0xAA55, carry 0, ovf 0.
  - clear -> 0x0000.
  - preset -> 0xFFFF.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, busy=1. Then raise out_ready with in_valid=1 (A+B, 0x1234+0x1111) -> accepted the same edge, next out_valid 4 edges later with 0x2345.
- Assert rst after 2 RUN cycles of 0xFFFF+0x0001 -> out_valid=0 and all outputs 0 at once; in_ready=1 after release; no stale result appears.
